// File: rtl/sram_controller.sv
// Data-memory responder: splits each 32-bit load/store into two 16-bit accesses
// on an external asynchronous SRAM, holding ready low while the access runs.
module sram_controller #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            sram_dq,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]             state;
    logic [3:0]             cnt;
    logic                   is_wr;
    logic [SRAM_ADDR_W-2:0] idx;
    logic [31:0]            wdata;
    logic [31:0]            offset;
    logic                   last;
    logic                   active;
    logic                   unused_bits;

    // Subtraction wraps naturally, so addresses below the base fold to the top of the SRAM.
    assign offset      = address - ADDR_BASE;
    assign unused_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};
    assign last        = (cnt == 4'(WAIT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            is_wr     <= 1'b0;
            idx       <= '0;
            wdata     <= 32'd0;
            read_data <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_en || rd_en) begin
                        is_wr <= wr_en;
                        idx   <= offset[SRAM_ADDR_W:2];
                        wdata <= write_data;
                        cnt   <= 4'd0;
                        state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (last) begin
                        if (!is_wr) read_data[15:0] <= sram_dq;
                        cnt   <= 4'd0;
                        state <= S_HIGH;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_HIGH: begin
                    if (last) begin
                        if (!is_wr) read_data[31:16] <= sram_dq;
                        cnt   <= 4'd0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded straight from state so reset releases the bus at once.
    assign active    = (state == S_LOW) || (state == S_HIGH);
    assign sram_ce_n = ~active;
    assign sram_ub_n = ~active;
    assign sram_lb_n = ~active;
    assign sram_we_n = ~(active & is_wr);
    assign sram_oe_n = ~(active & ~is_wr);
    assign sram_addr = active ? {idx, state == S_HIGH} : '0;
    assign sram_dq   = (active & is_wr) ? ((state == S_HIGH) ? wdata[31:16] : wdata[15:0]) : 16'hzzzz;

    assign ready = (state == S_DONE) || ((state == S_IDLE) && !rd_en && !wr_en);

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Responder side of the pipeline's data-memory interface: accepts the memory stage's word read/write requests and executes each as two 16-bit accesses on an external asynchronous SRAM.
- Sits between the memory stage and the SRAM pins.
- Its ready output drives the pipeline-wide freeze for as long as a transaction is in flight.

Parameters:
ADDR_BASE, 1024, byte address that maps to SRAM word 0; the mapped index is ((address - ADDR_BASE) >> 2) mod 2^(SRAM_ADDR_W-1).
WAIT_CYCLES, 2, clock cycles held per 16-bit half access; legal range 1..15.
SRAM_ADDR_W, 18, width of the SRAM half-word address bus.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
rd_en  in  1  word read request from the memory stage.
wr_en  in  1  word write request from the memory stage.
address  in  32  byte address of the request; bits [1:0] are ignored.
write_data  in  32  store data.
read_data  out  32  load data.
ready  out  1  high = no pending work or transaction completing; low = freeze the pipeline.
sram_dq  inout  16  SRAM data bus.
sram_addr  out  SRAM_ADDR_W  SRAM half-word address.
sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-transaction):
  - state=IDLE, wait counter=0, read_data=0.
  - sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n all =1; sram_addr=0; sram_dq released to Z.
  - The aborted write may leave the SRAM partially written.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If wr_en or rd_en is high, latch the operation (write wins if both are high), the word index and write_data; go to LOW with counter=0.
  - Otherwise stay in IDLE.
- LOW:
  - sram_addr={idx,1'b0}; ce_n=ub_n=lb_n=0.
  - Write: we_n=0, oe_n=1, dq driven with write_data[15:0].
  - Read: we_n=1, oe_n=0, dq=Z.
  - Counter increments each cycle. In the cycle where counter==WAIT_CYCLES-1: on a read, capture sram_dq into read_data[15:0]; then go to HIGH with counter=0.
- HIGH:
  - Same as LOW with sram_addr={idx,1'b1} and write data write_data[31:16].
  - On a read, capture sram_dq into read_data[31:16] at the final cycle; then go to DONE.
- DONE:
  - One cycle; all strobes inactive, dq=Z.
  - Go to IDLE unconditionally; no new request is accepted in this cycle.
- ready (combinational) = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en).
  - ready falls in the same cycle a request appears.
  - ready rises only in DONE.
- Latency: a request first seen in IDLE at cycle 0 gives ready=1 at cycle 2*WAIT_CYCLES+1. With the defaults this is cycle 5, so the request is frozen for 5 cycles.
- The pipeline advances at the end of the DONE cycle. A back-to-back request is sampled in the following IDLE cycle, with no bubble beyond DONE.
- read_data:
  - Valid from the DONE cycle onward.
  - Held until the next read overwrites it; writes never change it.
- Requests are latched in IDLE. Deasserting rd_en/wr_en or changing address/write_data mid-transaction has no effect; the transaction completes and DONE still occurs.
- Addresses below ADDR_BASE wrap modulo 2^(SRAM_ADDR_W-1) words; no error indication.
- SRAM strobes are decoded from state, so they are not registered.
- sram_dq is driven only in write LOW/HIGH cycles; it is never driven while oe_n=0.

Test Plan:
- Write address=1024, data=0xDEADBEEF, defaults:
  - ready=0 for cycles 0-4 and 1 at cycle 5.
  - sram_addr=0 with dq=0xBEEF and we_n=0 for 2 cycles, then sram_addr=1 with dq=0xDEAD for 2 cycles.
- Read address=1028, SRAM model holding half-words 2=0x5678 and 3=0x1234:
  - read_data=0x12345678 at cycle 5.
  - we_n=1 and oe_n=0 during LOW/HIGH.
  - dq never driven by the DUT.
- Back-to-back write then read of the same address (1032, 0xCAFEF00D):
  - Second transaction starts the cycle after DONE.
  - read_data=0xCAFEF00D with ready=1 at cycle 11.
- rst pulsed low during the HIGH state of a write:
  - Immediately: we_n=1, ce_n=1, dq=Z, read_data=0.
  - After release, ready=1 with no request pending.
- rd_en and wr_en both high at address 1024: executed as a write and read_data unchanged.
- WAIT_CYCLES=1 with a request at address 1020: sram_addr wraps to 2^18-2 then 2^18-1 and ready=1 at cycle 3.
